// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding decode.
// Owns the PC and keeps up to QDEPTH in-order requests in flight to instruction
// memory. Returned words are buffered in a QDEPTH-entry FIFO whose head is shown
// on registered outputs {instr_o, pc_o, pc_plus4_o} with a valid/ready handshake.
// A redirect flushes the FIFO and squashes responses still in flight.
//
// Ports:
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   imem_req_o, imem_addr_o           request valid / word address (pc_q)
//   imem_gnt_i                        request accepted this cycle
//   imem_rvalid_i, imem_rdata_i       in-order response valid / instruction word
//   redirect_i, redirect_pc_i         flush and restart at redirect_pc_i & ~3
//   valid_o, ready_i                  decode handshake
//   instr_o, pc_o, pc_plus4_o         head instruction, its address, address + 4
// Optional (macro FETCH_STATS_EN):
//   stat_fetched_o, stat_stall_o, stat_squash_o   saturating event counters
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched_o,
  output logic [31:0] stat_stall_o,
  output logic [31:0] stat_squash_o
`endif
);

  localparam int unsigned CW  = $clog2(QDEPTH + 1);
  localparam int unsigned PW  = $clog2(QDEPTH);
  localparam int unsigned SW  = CW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   pc_q;
  logic [CW-1:0] outstanding_q, drop_q, count_q;
  logic [PW-1:0] rd_q, wr_q, ifq_rd_q, ifq_wr_q;
  logic [31:0]   fifo_instr [QDEPTH];
  logic [31:0]   fifo_pc    [QDEPTH];
  logic [31:0]   ifq_pc     [QDEPTH];

  logic          pop, gnt, rsp, drop, push, valid_n;
  logic [SW-1:0] used;
  logic [CW-1:0] outstanding_n, drop_n, count_n, count_kept;
  logic [PW-1:0] rd_n, wr_n;
  logic [31:0]   pc_n, instr_n, head_pc_n;

  // Only word-aligned restart targets are used.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc_i[1:0];

  assign imem_addr_o = pc_q;

  // Handshake and credit: in-flight requests plus buffered words never exceed QDEPTH.
  always_comb begin
    pop        = valid_o & ready_i;
    used       = SW'(outstanding_q) + SW'(count_q) - SW'(pop);
    imem_req_o = rst_ni & !redirect_i & (used < SW'(QDEPTH));
    gnt        = imem_req_o & imem_gnt_i;
    rsp        = imem_rvalid_i & (outstanding_q != '0);
    drop       = rsp & (drop_q != '0);
    push       = rsp & (drop_q == '0) & !redirect_i;
  end

  // Next-state for PC, counters, FIFO pointers and the registered head view.
  always_comb begin
    pc_n          = gnt ? pc_q + 32'd4 : pc_q;
    outstanding_n = outstanding_q + CW'(gnt) - CW'(rsp);
    drop_n        = drop_q - CW'(drop);
    count_kept    = count_q - CW'(pop);
    count_n       = count_kept + CW'(push);
    rd_n          = rd_q + PW'(pop);
    wr_n          = wr_q + PW'(push);
    if (redirect_i) begin
      pc_n    = {redirect_pc_i[31:2], 2'b00};
      // No grant can happen this cycle, so only the response adjusts the count.
      drop_n  = outstanding_q - CW'(rsp);
      count_n = '0;
      rd_n    = '0;
      wr_n    = '0;
    end
    valid_n   = (count_n != '0);
    instr_n   = instr_o;
    head_pc_n = pc_o;
    if (valid_n) begin
      // A word pushed into a FIFO that is otherwise drained becomes the head directly.
      if (count_kept == '0) begin
        instr_n   = imem_rdata_i;
        head_pc_n = ifq_pc[ifq_rd_q];
      end else begin
        instr_n   = fifo_instr[rd_n];
        head_pc_n = fifo_pc[rd_n];
      end
    end
  end

  // Control state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      count_q       <= '0;
      rd_q          <= '0;
      wr_q          <= '0;
      ifq_rd_q      <= '0;
      ifq_wr_q      <= '0;
      valid_o       <= 1'b0;
      instr_o       <= NOP;
      pc_o          <= RESET_PC;
      pc_plus4_o    <= RESET_PC + 32'd4;
    end else begin
      pc_q          <= pc_n;
      outstanding_q <= outstanding_n;
      drop_q        <= drop_n;
      count_q       <= count_n;
      rd_q          <= rd_n;
      wr_q          <= wr_n;
      ifq_rd_q      <= ifq_rd_q + PW'(rsp);
      ifq_wr_q      <= ifq_wr_q + PW'(gnt);
      valid_o       <= valid_n;
      instr_o       <= instr_n;
      pc_o          <= head_pc_n;
      pc_plus4_o    <= head_pc_n + 32'd4;
    end
  end

  // Storage arrays: contents are only read behind valid pointers, so no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_instr[wr_q] <= imem_rdata_i;
      fifo_pc[wr_q]    <= ifq_pc[ifq_rd_q];
    end
    if (gnt) begin
      ifq_pc[ifq_wr_q] <= pc_q;
    end
  end

`ifdef FETCH_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_fetched_o <= '0;
      stat_stall_o   <= '0;
      stat_squash_o  <= '0;
    end else begin
      if (pop && (stat_fetched_o != '1)) stat_fetched_o <= stat_fetched_o + 32'd1;
      if (valid_o && !ready_i && (stat_stall_o != '1)) stat_stall_o <= stat_stall_o + 32'd1;
      if (rsp && (drop || redirect_i) && (stat_squash_o != '1)) stat_squash_o <= stat_squash_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + randomized bench for fetch_unit. A memory model with
// configurable latency answers granted requests in order; a program-order
// scoreboard expects decode to see consecutive word addresses starting at the
// reset PC or the latest aligned redirect target, each with the model's word.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk, rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        valid, ready;
  logic [31:0] instr, pc, pc_plus4;

  fetch_unit #(.RESET_PC(RST_PC), .QDEPTH(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(imem_gnt),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .valid_o(valid), .ready_i(ready),
    .instr_o(instr), .pc_o(pc), .pc_plus4_o(pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned passed = 0, total = 0, cyc = 0, pops = 0, lat = 1, bubbles = 0, stall_seen = 0;
  int          first_fire = -1, first_valid = -1;
  bit          rand_lat = 0, track_bubbles = 0, expect_req_low = 0;
  logic        prev_hold = 1'b0, redir_prev = 1'b0;
  logic [31:0] prev_addr = '0, exp_pc = RST_PC, last_pop_pc = '0;
  logic [31:0] mq_a [$];
  int unsigned mq_d [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive_mem();
    if (mq_a.size() != 0 && mq_d[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mq_a[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  endtask

  // One clock: check at the falling edge, then advance memory and drive after the rising edge.
  task automatic step();
    logic        fire, rsp;
    logic [31:0] a;
    @(negedge clk);
    if (redir_prev) chk("valid_after_redirect", 32'(valid), 32'd0);
    if (prev_hold && !redirect) begin
      chk("req_held", 32'(imem_req), 32'd1);
      chk("addr_held", imem_addr, prev_addr);
    end
    if (expect_req_low) chk("req_no_credit", 32'(imem_req), 32'd0);
    if (valid && first_valid < 0) first_valid = int'(cyc);
    if (track_bubbles && !valid) bubbles++;
    if (valid && !ready) begin
      stall_seen++;
      chk("stall_head_pc", pc, exp_pc);
      chk("stall_head_instr", instr, mem_word(exp_pc));
    end
    if (valid && ready) begin
      chk("pc", pc, exp_pc);
      chk("instr", instr, mem_word(exp_pc));
      chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
      last_pop_pc = pc;
      exp_pc      = exp_pc + 32'd4;
      pops++;
    end
    if (redirect) begin
      chk("req_in_redirect", 32'(imem_req), 32'd0);
      exp_pc = {redirect_pc[31:2], 2'b00};
    end
    fire       = imem_req & imem_gnt;
    rsp        = imem_rvalid;
    a          = imem_addr;
    if (fire && first_fire < 0) first_fire = int'(cyc);
    prev_hold  = imem_req & !imem_gnt;
    prev_addr  = a;
    redir_prev = redirect;
    @(posedge clk);
    cyc++;
    #1;
    if (rsp && mq_a.size() != 0) begin
      void'(mq_a.pop_front());
      void'(mq_d.pop_front());
    end
    if (rand_lat) lat = $urandom_range(1, 3);
    if (fire) begin
      mq_a.push_back(a);
      mq_d.push_back(cyc - 1 + lat);
    end
    drive_mem();
  endtask

  task automatic wait_pop(input string tag, input logic [31:0] want);
    int unsigned p0;
    int          n;
    p0 = pops;
    n  = 0;
    while (pops == p0 && n < 40) begin
      step();
      n++;
    end
    chk(tag, (pops != p0) ? last_pop_pc : 32'hFFFF_FFFF, want);
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    step();
    redirect    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; ready = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state
    repeat (2) step();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", pc, RST_PC);
    chk("rst_pc_plus4", pc_plus4, RST_PC + 32'd4);
    rst_n = 1'b1;

    // Single-cycle memory streaming: latency 2 from first grant, then no bubbles
    for (int i = 0; i < 10; i++) step();
    chk("first_valid_latency", 32'(first_valid - first_fire), 32'd2);
    track_bubbles = 1;
    for (int i = 0; i < 8; i++) step();
    track_bubbles = 0;
    chk("no_bubbles", 32'(bubbles), 32'd0);
    chk("stream_pops", 32'(pops), 32'd16);

    // Stall for 5 cycles: head stable, requests stop once credits are used
    ready = 1'b0;
    expect_req_low = 1;
    for (int i = 0; i < 5; i++) step();
    expect_req_low = 0;
    chk("stall_cycles", 32'(stall_seen), 32'd5);
    ready = 1'b1;
    for (int i = 0; i < 6; i++) step();

    // 3-cycle memory with two requests in flight, then redirect
    lat = 3;
    for (int i = 0; i < 12 && mq_a.size() != 2; i++) step();
    chk("two_in_flight", 32'(mq_a.size()), 32'd2);
    do_redirect(32'h0000_0100);
    wait_pop("redirect_0x100", 32'h0000_0100);
    for (int i = 0; i < 6; i++) step();

    // Misaligned target is word-aligned
    lat = 1;
    do_redirect(32'h0000_0206);
    wait_pop("redirect_0x206", 32'h0000_0204);
    for (int i = 0; i < 4; i++) step();

    // Back-to-back redirects: the last wins
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0040;
    step();
    do_redirect(32'h0000_0080);
    wait_pop("redirect_last_wins", 32'h0000_0080);
    for (int i = 0; i < 4; i++) step();

    // PC wrap at the top of the address space
    do_redirect(32'hFFFF_FFF8);
    wait_pop("redirect_wrap", 32'hFFFF_FFF8);
    for (int i = 0; i < 6; i++) step();
    chk("wrap_progress", exp_pc[31:16] == 16'h0000 ? 32'd1 : 32'd0, 32'd1);

    // Randomized traffic: grants, stalls, latencies and redirects
    rand_lat = 1;
    for (int i = 0; i < 400; i++) begin
      imem_gnt    = ($urandom_range(0, 9) < 7);
      ready       = ($urandom_range(0, 9) < 7);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      step();
    end
    rand_lat = 0;
    lat      = 1;
    imem_gnt = 1'b1;
    redirect = 1'b0;

    // Fill the FIFO, then reset asynchronously mid-stream
    ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    expect_req_low = 1;
    step();
    expect_req_low = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(valid), 32'd0);
    chk("async_rst_req", 32'(imem_req), 32'd0);
    chk("async_rst_pc", pc, RST_PC);
    chk("async_rst_instr", instr, NOP);
    mq_a.delete();
    mq_d.delete();
    imem_rvalid = 1'b0;
    prev_hold   = 1'b0;
    redir_prev  = 1'b0;
    exp_pc      = RST_PC;
    ready       = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    wait_pop("restart_after_reset", RST_PC);
    for (int i = 0; i < 6; i++) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Owns the PC and issues in-order requests to instruction memory, with up to QDEPTH requests in flight.
- Buffers returned words in a small FIFO and presents {instr, pc, pc+4} to decode with a valid/ready handshake. Decode takes op_i from instr_o[6:0].
- A redirect from execute (taken branch, jal, jalr) flushes the FIFO and squashes in-flight responses. Decode sees only bubbles until the new path arrives.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- QDEPTH, 2, FIFO entries and also the maximum number of outstanding requests; power of two, minimum 2.

Ports:
- clk_i, input, 1, clock; all state on rising edge.
- rst_ni, input, 1, asynchronous active-low reset.
- imem_req_o, output, 1, request valid.
- imem_addr_o, output, 32, request word address, equal to pc_q.
- imem_gnt_i, input, 1, memory accepts the request this cycle.
- imem_rvalid_i, input, 1, response valid; responses return in order, one per granted request.
- imem_rdata_i, input, 32, response instruction word.
- redirect_i, input, 1, flush and restart fetch.
- redirect_pc_i, input, 32, restart target.
- valid_o, output, 1, instr_o/pc_o/pc_plus4_o hold a valid instruction.
- ready_i, input, 1, decode consumes the instruction this cycle; deasserted by the hazard unit to stall.
- instr_o, output, 32, instruction word.
- pc_o, output, 32, address of instr_o.
- pc_plus4_o, output, 32, pc_o + 4, used for the jal/jalr link value.

Behaviour:
- Reset, asynchronous on rst_ni low:
  - pc_q = RESET_PC.
  - FIFO empty, outstanding = 0, drop_cnt = 0.
  - imem_req_o = 0, valid_o = 0.
  - instr_o = 32'h0000_0013 (nop), pc_o = RESET_PC, pc_plus4_o = RESET_PC + 4.
  - Reset asserted mid-operation discards all state. Memory must be reset together, so no pre-reset response arrives after release.
- Credit:
  - pop = valid_o & ready_i.
  - imem_req_o = !redirect_i & (outstanding + count - pop < QDEPTH).
  - imem_req_o, once high, stays high with a stable address until granted, unless redirect_i arrives.
- Grant (imem_req_o & imem_gnt_i): pc_q <= pc_q + 4 (32-bit wrap, 32'hFFFF_FFFC -> 0); outstanding++.
- Response (imem_rvalid_i):
  - Always outstanding--.
  - If drop_cnt != 0: discard the word, drop_cnt--.
  - Otherwise push {imem_rdata_i, pc of the matching request} into the FIFO; the pc comes from a QDEPTH-deep in-flight PC queue.
  - imem_rvalid_i with outstanding == 0 is a protocol error: ignored, counters unchanged.
- Grant and response in the same cycle: outstanding unchanged.
- FIFO:
  - Registered outputs: valid_o = count != 0; outputs show the head entry.
  - Push and pop in the same cycle are both performed, including when the FIFO is full.
  - The credit rule guarantees no overflow.
  - Empty FIFO: valid_o = 0; outputs hold their last values.
- Latency and throughput:
  - A grant in cycle N with rvalid in N+1 gives valid_o in N+2.
  - Single-cycle memory with ready_i = 1 sustains one instruction per cycle with no bubbles.
- Stall (ready_i = 0 with valid_o = 1): head entry and outputs stay stable. Fetching continues until credits run out.
- Redirect (redirect_i = 1):
  - Highest priority.
  - FIFO cleared next cycle (valid_o = 0).
  - pc_q <= {redirect_pc_i[31:2], 2'b00}.
  - drop_cnt <= outstanding after this cycle's response is accounted for.
  - imem_req_o is forced low this cycle.
  - A pop in the redirect cycle still counts as consumed.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- drop_cnt width is clog2(QDEPTH+1); it never exceeds QDEPTH.

Optional Feature:
- FETCH_STATS_EN defined: adds three 32-bit saturating counters and their ports, all reset to 0.
  - stat_fetched_o: increments per pop.
  - stat_stall_o: increments per cycle with valid_o & !ready_i.
  - stat_squash_o: increments per discarded response.
- Undefined: no counters and no ports; behaviour otherwise identical.

Test Plan:
- Release reset with RESET_PC=0 and single-cycle memory returning word = address: first valid_o 2 cycles after the first grant; pc_o = 0, 4, 8, 12 on consecutive cycles; pc_plus4_o = 4, 8, 12, 16.
- Hold ready_i = 0 for 5 cycles: pc_o stays at 8 and instr_o stable; imem_req_o drops once 2 credits are used; on release pc_o = 8, 12 with no loss or duplicates.
- Memory with 3-cycle latency and 2 requests in flight, redirect_i to 32'h100: both old responses dropped (stat_squash_o = 2 if enabled); next valid_o shows pc_o = 32'h100.
- redirect_pc_i = 32'h0000_0206: fetch restarts at 32'h204.
- Redirect two cycles in a row (0x40 then 0x80): only 0x80 appears on pc_o; no word from 0x40 reaches decode.
- Assert rst_ni low mid-stream with a full FIFO: valid_o = 0 and imem_req_o = 0 immediately (asynchronous); after release, fetch restarts at RESET_PC.
